// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding and default width shared by the serial arithmetic blocks
package serial_subtractor_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake between a controlling FSM and the serial subtractor
interface serial_subtractor_if import serial_subtractor_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  modport master (output start, a, b, bin, input busy, done, diff, bout, zero);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit difference/borrow cell, d = a - b - bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first through one full_subtractor cell and a borrow FF
module serial_subtractor import serial_subtractor_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clock,
  input  logic                reset_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_next;
  logic [CW-1:0]    count;
  logic             borrow, d, borrow_next, last;
  full_subtractor u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (borrow),
    .d   (d),
    .bout(borrow_next)
  );
  assign d_next   = {d, d_sh[WIDTH-1:1]};
  assign last     = count == CW'(WIDTH - 1);
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_DONE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      count    <= '0;
      borrow   <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.zero <= 1'b0;
    end else if (state == S_IDLE) begin
      if (bus.start) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        borrow <= bus.bin;
        count  <= '0;
        state  <= S_SHIFT;
      end
    end else if (state == S_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      d_sh   <= d_next;
      borrow <= borrow_next;
      count  <= count + 1'b1;
      // results are published only here so they stay stable between completions
      if (last) begin
        bus.diff <= d_next;
        bus.bout <= borrow_next;
        bus.zero <= d_next == '0;
        state    <= S_DONE;
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat, last_done;
  logic fa, fb, fbi, fd, fbo;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  serial_subtractor_if #(.WIDTH(W)) ifc ();
  serial_subtractor #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(ifc));
  full_subtractor u_fs (.a(fa), .b(fb), .bin(fbi), .d(fd), .bout(fbo));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_diff(int a, int b, int bi);
    return (a - b - bi) & ((1 << W) - 1);
  endfunction

  function automatic int ref_bout(int a, int b, int bi);
    return (a < b + bi) ? 1 : 0;
  endfunction

  task automatic do_op(input int a, input int b, input int bi);
    logic [W-1:0] old;
    int n, busy_cnt, ed;
    ed = ref_diff(a, b, bi);
    @(negedge clock);
    old = ifc.diff;
    ifc.a = W'(a);
    ifc.b = W'(b);
    ifc.bin = 1'(bi);
    ifc.start = 1'b1;
    @(negedge clock);
    ifc.start = 1'b0;
    ifc.a = W'($urandom);
    ifc.b = W'($urandom);
    ifc.bin = 1'($urandom);
    n = 0;
    busy_cnt = 0;
    while (!ifc.done && n < 3 * W) begin
      busy_cnt += int'(ifc.busy);
      check("hold", ifc.diff, old);
      @(negedge clock);
      n++;
    end
    check("latency", n, W);
    busy_cnt += int'(ifc.busy);
    check("busy_len", busy_cnt, W + 1);
    check("diff", ifc.diff, ed);
    check("bout", ifc.bout, ref_bout(a, b, bi));
    check("zero", ifc.zero, ed == 0);
    @(negedge clock);
    check("done_pulse", ifc.done, 0);
    check("idle", ifc.busy, 0);
    check("diff_keep", ifc.diff, ed);
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.bin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fa = i[2];
      fb = i[1];
      fbi = i[0];
      #1;
      check("fs_d", fd, (int'(fa) - int'(fb) - int'(fbi)) & 1);
      check("fs_bout", fbo, ((int'(fa) - int'(fb) - int'(fbi)) >> 1) & 1);
    end
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_diff", ifc.diff, 0);
    check("rst_bout", ifc.bout, 0);
    check("rst_zero", ifc.zero, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    do_op(9, 3, 0);
    do_op(3, 9, 0);
    do_op(5, 5, 0);
    do_op(0, 0, 1);
    @(negedge clock);
    ifc.a = 15;
    ifc.b = 0;
    ifc.bin = 0;
    ifc.start = 1'b1;
    last_done = -1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (!ifc.busy && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      ifc.a = 0;
      ifc.b = 1;
      lat = 0;
      while (!ifc.done && lat < 3 * W) begin
        @(negedge clock);
        lat++;
      end
      check("held_done", ifc.done, 1);
      check("held_diff", ifc.diff, 15);
      check("held_bout", ifc.bout, 0);
      if (k > 0) check("held_gap", cyc - last_done, W + 2);
      last_done = cyc;
      ifc.a = 15;
      ifc.b = 0;
      if (k == 2) ifc.start = 1'b0;
      @(negedge clock);
      check("held_once", ifc.done, 0);
    end
    @(negedge clock);
    ifc.a = 12;
    ifc.b = 7;
    ifc.bin = 0;
    ifc.start = 1'b1;
    @(negedge clock);
    ifc.start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", ifc.busy, 0);
    check("abort_done", ifc.done, 0);
    check("abort_diff", ifc.diff, 0);
    check("abort_bout", ifc.bout, 0);
    check("abort_zero", ifc.zero, 0);
    repeat (3) begin
      @(negedge clock);
      check("abort_nodone", ifc.done, 0);
    end
    reset_n = 1'b1;
    do_op(12, 7, 0);
    repeat (500) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), $urandom_range(0, 1));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
